// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round controller.
package aes_pkg;

    localparam int unsigned NR = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StFinal,
        StDone
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between requester/datapath and the round controller.
interface aes_round_ctrl_if;

    logic       start_i;
    logic       ready_o;
    logic       abort_i;
    logic       load_o;
    logic       state_en_o;
    logic       key_en_o;
    logic       sel_mix_o;
    logic [3:0] round_o;
    logic [7:0] rcon_o;
    logic       out_valid_o;
    logic       out_ready_i;

    modport master (
        output start_i,
        output abort_i,
        output out_ready_i,
        input  ready_o,
        input  load_o,
        input  state_en_o,
        input  key_en_o,
        input  sel_mix_o,
        input  round_o,
        input  rcon_o,
        input  out_valid_o
    );

    modport slave (
        input  start_i,
        input  abort_i,
        input  out_ready_i,
        output ready_o,
        output load_o,
        output state_en_o,
        output key_en_o,
        output sel_mix_o,
        output round_o,
        output rcon_o,
        output out_valid_o
    );

endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads to RCON_INIT or advances by one xtime step.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] rcon_o
);

    logic [7:0] r_rcon;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rcon <= RCON_INIT;
        end else if (load_i) begin
            r_rcon <= RCON_INIT;
        end else if (step_i) begin
            r_rcon <= xtime(r_rcon);
        end
    end

    assign rcon_o = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: one round per cycle, key schedule stepped in lockstep.
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic            clk,
    input  logic            reset,
    aes_round_ctrl_if.slave bus
);

    aes_pkg::aes_state_e r_state;
    logic [3:0]          r_round;
    logic                r_ready;
    logic                r_st_en;
    logic                r_key_en;
    logic                r_sel_mix;
    logic                r_out_valid;

    logic                w_accept;
    logic                w_rcon_load;
    logic [7:0]          w_rcon;

    // Only the IDLE-state enables are Mealy; abort and reset both mask them.
    assign w_accept    = r_ready & bus.start_i & ~bus.abort_i & ~reset;
    assign w_rcon_load = bus.abort_i | ((r_state == aes_pkg::StDone) & bus.out_ready_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= aes_pkg::StIdle;
            r_round     <= 4'd0;
            r_ready     <= 1'b1;
            r_st_en     <= 1'b0;
            r_key_en    <= 1'b0;
            r_sel_mix   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (bus.abort_i) begin
            r_state     <= aes_pkg::StIdle;
            r_round     <= 4'd0;
            r_ready     <= 1'b1;
            r_st_en     <= 1'b0;
            r_key_en    <= 1'b0;
            r_sel_mix   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                aes_pkg::StIdle: begin
                    if (bus.start_i) begin
                        r_state   <= aes_pkg::StRound;
                        r_round   <= 4'd1;
                        r_ready   <= 1'b0;
                        r_st_en   <= 1'b1;
                        r_key_en  <= 1'b1;
                        r_sel_mix <= 1'b1;
                    end
                end
                aes_pkg::StRound: begin
                    r_round <= r_round + 4'd1;
                    if (r_round == 4'(NR - 1)) begin
                        r_state   <= aes_pkg::StFinal;
                        r_key_en  <= 1'b0;
                        r_sel_mix <= 1'b0;
                    end
                end
                aes_pkg::StFinal: begin
                    r_state     <= aes_pkg::StDone;
                    r_st_en     <= 1'b0;
                    r_out_valid <= 1'b1;
                end
                aes_pkg::StDone: begin
                    // Exit to IDLE only; a concurrent start is taken next cycle at the earliest.
                    if (bus.out_ready_i) begin
                        r_state     <= aes_pkg::StIdle;
                        r_round     <= 4'd0;
                        r_ready     <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk    (clk),
        .reset  (reset),
        .load_i (w_rcon_load),
        .step_i (bus.key_en_o),
        .rcon_o (w_rcon)
    );

    assign bus.ready_o     = r_ready;
    assign bus.load_o      = w_accept;
    assign bus.state_en_o  = r_st_en | w_accept;
    assign bus.key_en_o    = r_key_en | w_accept;
    assign bus.sel_mix_o   = r_sel_mix;
    assign bus.round_o     = r_round;
    assign bus.rcon_o      = w_rcon;
    assign bus.out_valid_o = r_out_valid;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: cycle-timeline checks plus an AES datapath model driven by the controller.
module tb_aes_round_ctrl;

    logic clk;
    logic reset;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(
        .NR (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    logic [7:0]   sbox [256];
    logic [7:0]   rcon_tab [10];
    logic [127:0] dp_pt;
    logic [127:0] dp_kin;
    logic [127:0] dp_state;
    logic [127:0] dp_key;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [7:0]   b [16];
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox[b[r+4*((c+r)%4)]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ key;
        logic [127:0] k = key;
        logic [7:0]   rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k  = key_next(k, rc);
            rc = gmul(rc, 8'h02);
            s  = sub_shift(s);
            if (r < 10) s = mix(s);
            s = s ^ k;
        end
        return s;
    endfunction

    // Datapath model steered only by the controller's outputs.
    always @(posedge clk) begin
        if (bus.load_o) begin
            dp_state <= dp_pt ^ dp_kin;
            dp_key   <= key_next(dp_kin, bus.rcon_o);
        end else begin
            if (bus.state_en_o)
                dp_state <= bus.sel_mix_o ? (mix(sub_shift(dp_state)) ^ dp_key)
                                          : (sub_shift(dp_state) ^ dp_key);
            if (bus.key_en_o) dp_key <= key_next(dp_key, bus.rcon_o);
        end
    end

    function automatic logic [127:0] pack(input bit rdy, input bit ld, input bit sten,
                                          input bit ken, input bit sel, input bit ov,
                                          input logic [3:0] rnd, input logic [7:0] rc);
        return {110'b0, rdy, ld, sten, ken, sel, ov, rnd, rc};
    endfunction

    function automatic logic [127:0] obs(input bit with_rcon);
        return {110'b0, bus.ready_o, bus.load_o, bus.state_en_o, bus.key_en_o, bus.sel_mix_o,
                bus.out_valid_o, bus.round_o, with_rcon ? bus.rcon_o : 8'h00};
    endfunction

    function automatic logic [127:0] idle_vec();
        return pack(1, 0, 0, 0, 0, 0, 4'd0, 8'h01);
    endfunction

    // Starts one block and walks its cycle timeline; abort_at/reset_at < 0 disables the break.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp_ct, input int hold,
                             input int abort_at, input int reset_at);
        logic [127:0] exp;
        dp_pt           = pt;
        dp_kin          = key;
        bus.start_i     = 1'b1;
        bus.abort_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k == abort_at) bus.abort_i = 1'b1;
            @(negedge clk);
            if (k == 0)       exp = pack(1, 1, 1, 1, 0, 0, 4'd0, rcon_tab[0]);
            else if (k < 10)  exp = pack(0, 0, 1, 1, 1, 0, 4'(k), rcon_tab[k]);
            else              exp = pack(0, 0, 1, 0, 0, 0, 4'd10, 8'h00);
            check($sformatf("ctrl_c%0d", k), obs(k < 10), exp);
            if (k == reset_at) begin
                #2;
                reset       = 1'b1;
                bus.start_i = 1'b0;
                #1;
                check("reset_async", obs(1), idle_vec());
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.start_i = 1'($urandom_range(0, 1));
            if (k == abort_at) begin
                bus.abort_i = 1'b0;
                bus.start_i = 1'b0;
                @(negedge clk);
                check("abort_idle", obs(1), idle_vec());
                @(posedge clk);
                #1;
                return;
            end
        end
        for (int d = 0; d <= hold; d++) begin
            bus.out_ready_i = (d == hold);
            bus.start_i     = (d == hold) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("ctrl_done%0d", d), obs(0), pack(0, 0, 0, 0, 0, 1, 4'd10, 8'h00));
            check($sformatf("cipher_done%0d", d), dp_state, exp_ct);
            @(posedge clk);
            #1;
        end
        bus.out_ready_i = 1'b0;
        bus.start_i     = 1'b0;
        @(negedge clk);
        check("back_idle", obs(1), idle_vec());
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        bus.start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_gap", obs(1), idle_vec());
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run, want completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] pt, key;
        logic [7:0]   inv;
        int           ab;
        n_checks = 0;
        n_pass   = 0;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        reset           = 1'b1;
        bus.start_i     = 1'b1;
        bus.abort_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        #3;
        check("reset_state", obs(1), idle_vec());
        @(posedge clk);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.start_i = 1'b0;

        pt  = 128'h3243f6a8885a308d313198a2e0370734;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        run_block(pt, key, 128'h3925841d02dc09fbdc118597196a0b32, 5, -1, -1);
        run_block(pt, key, 128'h0, 0, 5, -1);
        run_block(pt, key, 128'h3925841d02dc09fbdc118597196a0b32, 0, -1, -1);

        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        @(negedge clk);
        check("abort_over_start", obs(1), idle_vec());
        @(posedge clk);
        #1;
        bus.abort_i = 1'b0;
        idle_cycles(1);

        run_block({$urandom, $urandom, $urandom, $urandom}, key, 128'h0, 0, -1, 7);
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        run_block(pt, key, aes_ref(pt, key), 1, -1, -1);

        for (int n = 0; n < 20; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
            run_block(pt, key, aes_ref(pt, key), int'($urandom_range(0, 5)), ab, -1);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, 10, number of AES rounds; only 10 (AES-128) is supported and verified.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  requester has a block; plaintext and cipher key on datapath inputs are valid.
REQ-005 ready_o  output  1  controller idle; start is accepted when start_i & ready_o.
REQ-006 abort_i  input  1  synchronous abort of the operation in progress.
REQ-007 load_o  output  1  datapath selects external plaintext and cipher key as sources (round 0).
REQ-008 state_en_o  output  1  enables the datapath state register.
REQ-009 key_en_o  output  1  enables the round-key register; next round key is computed with rcon_o.
REQ-010 sel_mix_o  output  1  1 = MixColumns in path; 0 = bypass.
REQ-011 round_o  output  4  current round number, 0..10.
REQ-012 rcon_o  output  8  round constant applied while key_en_o = 1.
REQ-013 out_valid_o  output  1  ciphertext valid in the state register.
REQ-014 out_ready_i  input  1  consumer accepts the ciphertext.

Function
REQ-015 FSM states: IDLE, ROUND, FINAL, DONE.
REQ-016 IDLE: ready_o = 1, and load_o = state_en_o = key_en_o = start_i (Mealy); rcon_o = 8'h01; round_o = 0.
REQ-017 Acceptance (start_i & ready_o) -> ROUND with round counter 1; state <= plaintext ^ key; key register <= round key 1.
REQ-018 ROUND r (1..9): state_en_o = 1, sel_mix_o = 1, key_en_o = 1, rcon_o = rcon(r+1), round_o = r; counter increments; r = 9 -> FINAL.
REQ-019 FINAL: state_en_o = 1, sel_mix_o = 0, key_en_o = 0, round_o = 10; -> DONE.
REQ-020 DONE: out_valid_o = 1, round_o = 10, all enables 0; hold until out_ready_i = 1, then -> IDLE.
REQ-021 Latency: acceptance at cycle 0, rounds 1-9 at cycles 1-9, FINAL at cycle 10, out_valid_o high from cycle 11.
REQ-022 rcon sequence 01,02,04,08,10,20,40,80,1B,36; next = rcon<<1, XOR 8'h1B when rcon[7] = 1, computed in 8 bits.
REQ-023 ready_o = 1 only in IDLE; start_i outside IDLE is ignored with no effect.
REQ-024 DONE with out_ready_i = 1 and start_i = 1: return to IDLE only; start is accepted no earlier than the next cycle.
REQ-025 abort_i = 1 in any state: next state IDLE, counter 0, rcon 01; abort has priority over start and out_ready_i; while abort_i = 1, all Mealy enables are 0.
REQ-026 Outputs other than ready_o, load_o, state_en_o and key_en_o in IDLE are registered or decoded from state only.

Reset
REQ-027 reset = 1 forces IDLE asynchronously: round_o = 0, rcon_o = 8'h01, out_valid_o = 0, sel_mix_o = 0, state_en_o = key_en_o = load_o = 0, ready_o = 1.
REQ-028 Reset mid-operation discards the block; after release, the controller accepts a new start in the first cycle.

Structure
REQ-029 Shared package aes_pkg holds: the FSM state enum, NR, RCON_INIT = 8'h01, and an xtime function.
REQ-030 One sub-module, aes_rcon_gen (load/step inputs, 8-bit rcon output), is instantiated; the datapath stays outside this block.

Verification
REQ-031 Reset, then start_i = 1 for 1 cycle -> load_o = 1 at cycle 0; round_o = 1..9 at cycles 1-9; 10 at cycle 10; out_valid_o at cycle 11.
REQ-032 Same run -> rcon_o = 01 at cycle 0, then 02,04,08,10,20,40,80,1B,36 at cycles 1-9; key_en_o = 0 at cycle 10.
REQ-033 Integrated with the existing datapath: plaintext 3243f6a8885a308d313198a2e0370734 and key 2b7e151628aed2a6abf7158809cf4f3c -> ciphertext 3925841d02dc09fbdc118597196a0b32.
REQ-034 out_ready_i = 0 for 5 cycles in DONE -> out_valid_o held with a stable ciphertext; start_i pulses are ignored; out_ready_i = 1 -> IDLE, ready_o = 1 next cycle.
REQ-035 abort_i at round 5 -> IDLE next cycle, round_o = 0, rcon_o = 01, no out_valid_o; an immediate restart yields the correct ciphertext.
REQ-036 reset asserted at cycle 7 mid-block -> outputs take reset values immediately; after release, a new block completes in 11 cycles.
